fpro_mmio_ctrl: RTL and testbench
=================================

Name: fpro_mmio_ctrl

Overview:
- Downstream of the FPro system conduit. Consumes the MMIO bus (fp_mmio_cs/fp_read/fp_write/fp_addr/fp_writedata) and produces fp_readdata.
- Decodes each access into one of NUM_SLOTS I/O slots, 32 registers per slot, through a two-stage registered pipeline.
- Slot 0 is built in: a system slot with ID, cycle counter and an unmapped-access log.

Parameters:
- NUM_SLOTS, 16, number of slots including internal slot 0 (2..64).
- SYS_ID, 32'hF0A0_0001, constant returned by slot 0 reg 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mmio_cs  in  1  MMIO chip select.
- mmio_rd  in  1  read request.
- mmio_wr  in  1  write request.
- mmio_addr  in  21  word address: [20:11] must be 0; [10:5] slot; [4:0] register.
- mmio_wr_data  in  32  write data.
- mmio_rd_data  out  32  read data, fixed latency 2.
- slot_cs_array  out  NUM_SLOTS  registered one-hot slot select; bit 0 always 0.
- slot_mem_rd_array  out  NUM_SLOTS  registered read strobe per slot.
- slot_mem_wr_array  out  NUM_SLOTS  registered write strobe per slot.
- slot_reg_addr  out  5  registered register index, shared by all slots.
- slot_wr_data  out  32  registered write data, shared by all slots.
- slot_rd_data_array  in  32*NUM_SLOTS  slot read data; slot k occupies bits [32k+31:32k]; slots drive it combinationally from slot_reg_addr.

Behaviour:
- Request accepted when mmio_cs=1 and (mmio_rd or mmio_wr). One request per cycle, fully pipelined, no stalls.
- If rd and wr are both asserted, the request is treated as a write only.
- Stage 1 (cycle N+1 after request at N):
  - All slot outputs registered from the request.
  - Mapped external slot k (1..NUM_SLOTS-1): cs[k]=1, plus rd[k] or wr[k].
  - Unmapped request (addr[20:11]≠0 or slot≥NUM_SLOTS): no strobes; logged (see slot 0).
  - Slot 0 requests act on the internal registers in this cycle.
  - With no request, all strobes are 0; slot_reg_addr and slot_wr_data hold their last value.
- Stage 2 (cycle N+2):
  - For a read, mmio_rd_data is loaded from the selected slot_rd_data_array word, or from the slot 0 register.
  - Unmapped read returns 32'h0. Write-only requests do not update mmio_rd_data.
  - mmio_rd_data holds its value between reads.
- Slot 0 registers:
  - Reg 0: SYS_ID. Read-only.
  - Reg 1: cycle counter bits [31:0].
    - 64-bit free-running counter, +1 every clk, wraps at 2^64−1 → 0.
    - A read latches counter bits [63:32] into a shadow register in the same stage-1 cycle.
    - Any write clears the counter to 0; it increments from the following cycle.
  - Reg 2: shadow high word. Read-only.
  - Reg 3: unmapped-access count, 32-bit, saturates at 32'hFFFF_FFFF. Any write clears it to 0.
  - Reg 4: address of the last unmapped access, zero-extended to 32 bits.
  - Other regs: read 0, writes ignored.
  - The counter value returned by a reg 1 read is the value in the stage-1 cycle.
- Reset (synchronous, any cycle, including mid-pipeline):
  - All strobes, slot_cs_array, slot_reg_addr, slot_wr_data, mmio_rd_data, the cycle counter, shadow, unmapped count and last-address register go to 0.
  - In-flight requests are dropped.

Test Plan:
- After reset: mmio_rd_data=0, all strobes 0. Read addr 0x000 → 0xF0A0_0001 two cycles later.
- Write addr 0x023 (slot 1, reg 3), data 0x1234_5678 → next cycle: slot_mem_wr_array=16'h0002, slot_cs_array=16'h0002, slot_reg_addr=3, slot_wr_data=0x1234_5678, single cycle.
- Back-to-back reads of slots 2, 3, 2 (slot model returns 0xA000_0000+slot*16+reg) → three consecutive correct mmio_rd_data values, each exactly 2 cycles after its request.
- Read addr 0x10_0000, then addr 0x7E0 (slot 63, NUM_SLOTS=16) → no strobes; rd_data=0; reg 3 reads 2; reg 4 reads 0x0000_07E0. Write reg 3 → reg 3 reads 0.
- Write reg 1, wait 9 cycles, read reg 1 → value consistent with clear (fixed offset, checked exactly); reg 2 reads 0. Force the counter near 2^32 → shadow high word = 1 after the low-word read.
- rd and wr asserted together → only a wr strobe. Reset asserted in the cycle after a read request → no strobe, mmio_rd_data stays 0.

Source files
------------

// File: rtl/fpro_mmio_ctrl_if.sv
// FPro MMIO bus between the system conduit and the MMIO controller.
// A request is valid in any cycle where mmio_cs is high together with mmio_rd or mmio_wr.
// There is no ready: the slave accepts one request every cycle.
// Read data returns exactly two cycles later and holds until the next read.
interface fpro_mmio_ctrl_if;
  logic        mmio_cs;
  logic        mmio_rd;
  logic        mmio_wr;
  logic [20:0] mmio_addr;
  logic [31:0] mmio_wr_data;
  logic [31:0] mmio_rd_data;

  modport master (
    output mmio_cs, mmio_rd, mmio_wr, mmio_addr, mmio_wr_data,
    input  mmio_rd_data
  );

  modport slave (
    input  mmio_cs, mmio_rd, mmio_wr, mmio_addr, mmio_wr_data,
    output mmio_rd_data
  );
endinterface

// File: rtl/fpro_mmio_ctrl.sv
// FPro MMIO controller: decodes bus accesses into per-slot strobes through a
// two-stage pipeline and implements the built-in system slot 0.
module fpro_mmio_ctrl #(
  parameter int          NUM_SLOTS = 16,
  parameter logic [31:0] SYS_ID    = 32'hF0A0_0001
) (
  input  logic                      clk,
  input  logic                      reset,
  fpro_mmio_ctrl_if.slave           bus,
  output logic [NUM_SLOTS-1:0]      slot_cs_array,
  output logic [NUM_SLOTS-1:0]      slot_mem_rd_array,
  output logic [NUM_SLOTS-1:0]      slot_mem_wr_array,
  output logic [4:0]                slot_reg_addr,
  output logic [31:0]               slot_wr_data,
  input  logic [32*NUM_SLOTS-1:0]   slot_rd_data_array
);

  localparam logic [6:0] SLOT_LIMIT = 7'(NUM_SLOTS);

  // stage 0: request decode
  logic       req, req_rd, req_wr, addr_hi_zero, slot_in_range;
  logic       req_sys, req_unmapped, req_ext;
  logic [5:0] req_slot;
  logic [NUM_SLOTS-1:0] sel_next;

  assign req           = bus.mmio_cs & (bus.mmio_rd | bus.mmio_wr);
  assign req_wr        = req & bus.mmio_wr;
  assign req_rd        = req & bus.mmio_rd & ~bus.mmio_wr;  // rd+wr together is a write
  assign req_slot      = bus.mmio_addr[10:5];
  assign addr_hi_zero  = (bus.mmio_addr[20:11] == 10'd0);
  assign slot_in_range = ({1'b0, req_slot} < SLOT_LIMIT);
  assign req_unmapped  = req & ~(addr_hi_zero & slot_in_range);
  assign req_sys       = req & addr_hi_zero & (req_slot == 6'd0);
  assign req_ext       = req & ~req_unmapped & ~req_sys;

  always_comb begin
    sel_next = '0;
    for (int k = 1; k < NUM_SLOTS; k++) begin
      if (req_ext && (int'(req_slot) == k)) sel_next[k] = 1'b1;
    end
  end

  // stage 1: registered slot interface plus the pipeline tag for stage 2
  logic        s1_rd, s1_wr, s1_sys, s1_unmapped;
  logic [5:0]  s1_slot;
  logic [20:0] s1_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cs_array     <= '0;
      slot_mem_rd_array <= '0;
      slot_mem_wr_array <= '0;
      slot_reg_addr     <= '0;
      slot_wr_data      <= '0;
      s1_rd             <= 1'b0;
      s1_wr             <= 1'b0;
      s1_sys            <= 1'b0;
      s1_unmapped       <= 1'b0;
      s1_slot           <= '0;
      s1_addr           <= '0;
    end else begin
      slot_cs_array     <= sel_next;
      slot_mem_rd_array <= req_rd ? sel_next : '0;
      slot_mem_wr_array <= req_wr ? sel_next : '0;
      if (req) begin
        slot_reg_addr <= bus.mmio_addr[4:0];
        slot_wr_data  <= bus.mmio_wr_data;
      end
      s1_rd       <= req_rd;
      s1_wr       <= req_wr;
      s1_sys      <= req_sys;
      s1_unmapped <= req_unmapped;
      s1_slot     <= req_slot;
      s1_addr     <= bus.mmio_addr;
    end
  end

  // system slot registers, acted on during the stage-1 cycle
  logic [63:0] cycle_cnt;
  logic [31:0] shadow_hi;
  logic [31:0] unmapped_cnt;
  logic [20:0] last_unmapped_addr;
  logic        sys_rd, sys_wr;

  assign sys_rd = s1_rd & s1_sys;
  assign sys_wr = s1_wr & s1_sys;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt          <= '0;
      shadow_hi          <= '0;
      unmapped_cnt       <= '0;
      last_unmapped_addr <= '0;
    end else begin
      cycle_cnt <= (sys_wr && slot_reg_addr == 5'd1) ? 64'd0 : cycle_cnt + 64'd1;
      if (sys_rd && slot_reg_addr == 5'd1) shadow_hi <= cycle_cnt[63:32];
      if (sys_wr && slot_reg_addr == 5'd3) unmapped_cnt <= '0;
      else if (s1_unmapped && unmapped_cnt != 32'hFFFF_FFFF) unmapped_cnt <= unmapped_cnt + 32'd1;
      if (s1_unmapped) last_unmapped_addr <= s1_addr;
    end
  end

  logic [31:0] sys_rd_data, ext_rd_data;

  always_comb begin
    sys_rd_data = 32'd0;
    case (slot_reg_addr)
      5'd0:    sys_rd_data = SYS_ID;
      5'd1:    sys_rd_data = cycle_cnt[31:0];
      5'd2:    sys_rd_data = shadow_hi;
      5'd3:    sys_rd_data = unmapped_cnt;
      5'd4:    sys_rd_data = {11'd0, last_unmapped_addr};
      default: sys_rd_data = 32'd0;
    endcase
  end

  // slot 0's word is never selected here because s1_sys takes priority
  always_comb begin
    ext_rd_data = 32'd0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (int'(s1_slot) == k) ext_rd_data = slot_rd_data_array[32*k +: 32];
    end
  end

  // stage 2: read data register, loaded only by reads
  logic [31:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (s1_rd) begin
      if (s1_unmapped)  rd_data_q <= 32'd0;
      else if (s1_sys)  rd_data_q <= sys_rd_data;
      else              rd_data_q <= ext_rd_data;
    end
  end

  assign bus.mmio_rd_data = rd_data_q;

endmodule

// File: tb/tb_fpro_mmio_ctrl.sv
// Bench for fpro_mmio_ctrl: directed steps plus random traffic, checked against
// an address-arithmetic reference model of the slot map and system slot.
module tb_fpro_mmio_ctrl;
  localparam int          NS     = 16;
  localparam logic [31:0] SYS_ID = 32'hF0A0_0001;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpro_mmio_ctrl_if bus ();
  logic [NS-1:0]    cs_arr, rd_arr, wr_arr;
  logic [4:0]       reg_addr;
  logic [31:0]      wr_data;
  logic [32*NS-1:0] slot_rd;

  fpro_mmio_ctrl #(.NUM_SLOTS(NS), .SYS_ID(SYS_ID)) dut (
    .clk                (clk),
    .reset              (rst),
    .bus                (bus.slave),
    .slot_cs_array      (cs_arr),
    .slot_mem_rd_array  (rd_arr),
    .slot_mem_wr_array  (wr_arr),
    .slot_reg_addr      (reg_addr),
    .slot_wr_data       (wr_data),
    .slot_rd_data_array (slot_rd)
  );

  // external slot model: combinational read data from the shared register index
  always_comb begin
    for (int k = 0; k < NS; k++)
      slot_rd[32*k +: 32] = 32'hA000_0000 + 32'(k * 16) + {27'd0, reg_addr};
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver
  typedef struct packed {
    logic        v;
    logic        rd;
    logic        wr;
    logic [20:0] addr;
    logic [31:0] data;
  } req_t;
  req_t drv = '0;

  task automatic set_bus(input logic cs, input logic rd, input logic wr,
                         input logic [20:0] addr, input logic [31:0] data);
    bus.mmio_cs = cs; bus.mmio_rd = rd; bus.mmio_wr = wr;
    bus.mmio_addr = addr; bus.mmio_wr_data = data;
    drv.v = cs & (rd | wr); drv.rd = rd; drv.wr = wr; drv.addr = addr; drv.data = data;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [20:0] addr, input logic [31:0] data);
    set_bus(1'b1, rd, wr, addr, data);
    @(negedge clk);
    set_bus(1'b0, 1'b0, 1'b0, addr, data);
  endtask

  task automatic idle(input int n);
    set_bus(1'b0, 1'b0, 1'b0, bus.mmio_addr, bus.mmio_wr_data);
    repeat (n) @(negedge clk);
  endtask

  // reference model
  logic [31:0] exp_q[$];
  logic        model_on = 1'b0;
  req_t        s1_m = '0;
  logic [63:0] m_cnt = '0;
  logic        cnt_known = 1'b1, shadow_known = 1'b1, m_rd_known = 1'b1;
  logic [31:0] m_shadow = '0, m_ucnt = '0, m_rd = '0, m_wdata = '0;
  logic [20:0] m_uaddr = '0;
  logic [NS-1:0] m_cs = '0, m_rds = '0, m_wrs = '0;
  logic [4:0]  m_reg = '0;

  function automatic void ref_read(input logic [20:0] a, output logic [31:0] v, output logic k);
    int unsigned slot = int'(a) / 32;
    int unsigned r    = int'(a) % 32;
    k = 1'b1;
    v = 32'd0;
    if (int'(a) >= 32 * NS) v = 32'd0;
    else if (slot == 0) begin
      case (r)
        0: v = SYS_ID;
        1: begin v = m_cnt[31:0]; k = cnt_known; end
        2: begin v = m_shadow; k = shadow_known; end
        3: v = m_ucnt;
        4: v = {11'd0, m_uaddr};
        default: v = 32'd0;
      endcase
    end else v = 32'hA000_0000 + 32'(slot * 16 + r);
  endfunction

  always @(posedge clk) begin
    logic [31:0] rv;
    logic        rk, is_sys, unm, s1_read;
    int unsigned r, slot;
    if (rst) begin
      model_on = 1'b1; s1_m = '0; m_cnt = '0; cnt_known = 1'b1; shadow_known = 1'b1;
      m_shadow = '0; m_ucnt = '0; m_uaddr = '0; m_rd = '0; m_rd_known = 1'b1;
      m_cs = '0; m_rds = '0; m_wrs = '0; m_reg = '0; m_wdata = '0;
      exp_q.delete();
    end else if (model_on) begin
      is_sys  = s1_m.v && int'(s1_m.addr) < 32;
      unm     = s1_m.v && int'(s1_m.addr) >= 32 * NS;
      s1_read = s1_m.v && s1_m.rd && !s1_m.wr;
      r       = int'(s1_m.addr) % 32;
      if (s1_read) begin
        ref_read(s1_m.addr, rv, rk);
        exp_q.push_back(rv);
        m_rd_known = rk;
      end
      if (is_sys && s1_read && r == 1) begin m_shadow = m_cnt[63:32]; shadow_known = cnt_known; end
      if (is_sys && s1_m.wr && r == 1) begin m_cnt = '0; cnt_known = 1'b1; end
      else m_cnt = m_cnt + 64'd1;
      if (is_sys && s1_m.wr && r == 3) m_ucnt = '0;
      else if (unm && m_ucnt != 32'hFFFF_FFFF) m_ucnt = m_ucnt + 32'd1;
      if (unm) m_uaddr = s1_m.addr;
      m_cs = '0; m_rds = '0; m_wrs = '0;
      if (drv.v) begin
        m_reg = drv.addr[4:0];
        m_wdata = drv.data;
        slot = int'(drv.addr) / 32;
        if (int'(drv.addr) < 32 * NS && slot != 0) begin
          m_cs[slot] = 1'b1;
          if (drv.wr) m_wrs = m_cs; else m_rds = m_cs;
        end
      end
      s1_m = drv.v ? drv : '0;
    end
    #1;
    if (model_on) begin
      if (exp_q.size() > 0) m_rd = exp_q.pop_front();
      chk("cs_array", 64'(cs_arr), 64'(m_cs));
      chk("rd_array", 64'(rd_arr), 64'(m_rds));
      chk("wr_array", 64'(wr_arr), 64'(m_wrs));
      chk("reg_addr", 64'(reg_addr), 64'(m_reg));
      chk("wr_data", 64'(wr_data), 64'(m_wdata));
      if (m_rd_known) chk("rd_data", 64'(bus.mmio_rd_data), 64'(m_rd));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // directed steps and random traffic
  initial begin
    set_bus(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_rd_data", 64'(bus.mmio_rd_data), 64'd0);
    chk("reset_strobes", 64'(cs_arr | rd_arr | wr_arr), 64'd0);

    issue(1'b1, 1'b0, 21'h000, 32'd0); idle(1);
    chk("sys_id", 64'(bus.mmio_rd_data), 64'hF0A0_0001);

    issue(1'b0, 1'b1, 21'h023, 32'h1234_5678);
    chk("wr_strobe", 64'(wr_arr), 64'h0002);
    chk("wr_cs", 64'(cs_arr), 64'h0002);
    chk("wr_reg", 64'(reg_addr), 64'd3);
    chk("wr_data_out", 64'(wr_data), 64'h1234_5678);
    idle(1);
    chk("wr_single_cycle", 64'(wr_arr), 64'd0);

    issue(1'b1, 1'b0, 21'h045, 32'd0);   // slot 2 reg 5
    issue(1'b1, 1'b0, 21'h067, 32'd0);   // slot 3 reg 7
    chk("b2b_first", 64'(bus.mmio_rd_data), 64'hA000_0025);
    issue(1'b1, 1'b0, 21'h041, 32'd0);   // slot 2 reg 1
    chk("b2b_second", 64'(bus.mmio_rd_data), 64'hA000_0037);
    idle(1);
    chk("b2b_third", 64'(bus.mmio_rd_data), 64'hA000_0021);

    issue(1'b1, 1'b0, 21'h10_0000, 32'd0);
    issue(1'b1, 1'b0, 21'h7E0, 32'd0);
    chk("unmapped_no_strobe", 64'(cs_arr | rd_arr | wr_arr), 64'd0);
    chk("unmapped_rd_zero", 64'(bus.mmio_rd_data), 64'd0);
    issue(1'b1, 1'b0, 21'h003, 32'd0);
    issue(1'b1, 1'b0, 21'h004, 32'd0);
    chk("unmapped_count", 64'(bus.mmio_rd_data), 64'd2);
    idle(1);
    chk("unmapped_addr", 64'(bus.mmio_rd_data), 64'h7E0);
    issue(1'b0, 1'b1, 21'h003, 32'hDEAD_BEEF);
    issue(1'b1, 1'b0, 21'h003, 32'd0); idle(1);
    chk("unmapped_count_clr", 64'(bus.mmio_rd_data), 64'd0);

    issue(1'b0, 1'b1, 21'h001, 32'd0);
    idle(9);
    issue(1'b1, 1'b0, 21'h001, 32'd0);
    issue(1'b1, 1'b0, 21'h002, 32'd0);
    chk("cnt_after_clear", 64'(bus.mmio_rd_data), 64'd9);
    idle(1);
    chk("shadow_zero", 64'(bus.mmio_rd_data), 64'd0);

    issue(1'b1, 1'b1, 21'h022, 32'h0BAD_F00D);
    chk("rdwr_wr_strobe", 64'(wr_arr), 64'h0002);
    chk("rdwr_no_rd", 64'(rd_arr), 64'd0);

    // jump the counter just below 2^32 to see the high word carry into the shadow
    force dut.cycle_cnt = 64'h0000_0000_FFFF_FFF0;
    cnt_known = 1'b0;
    @(negedge clk);
    release dut.cycle_cnt;
    idle(30);
    issue(1'b1, 1'b0, 21'h001, 32'd0);
    issue(1'b1, 1'b0, 21'h002, 32'd0);
    chk("cnt_lo_wrapped", 64'(bus.mmio_rd_data < 32'd64), 64'd1);
    idle(1);
    chk("shadow_hi_one", 64'(bus.mmio_rd_data), 64'd1);
    issue(1'b0, 1'b1, 21'h001, 32'd0);
    issue(1'b1, 1'b0, 21'h001, 32'd0);
    issue(1'b1, 1'b0, 21'h002, 32'd0);
    idle(2);

    for (int i = 0; i < 400; i++) begin
      logic [20:0] a;
      int unsigned pick = $urandom_range(0, 9);
      if (pick == 0)      a = 21'($urandom_range(1, 2047)) << 11 | 21'($urandom_range(0, 2047));
      else if (pick < 3)  a = 21'($urandom_range(0, 6));
      else                a = 21'($urandom_range(0, NS + 1) * 32 + $urandom_range(0, 7));
      if ((pick == 2) && a == 21'd1) a = 21'd0;
      set_bus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
      @(negedge clk);
    end
    idle(2);

    issue(1'b1, 1'b0, 21'h040, 32'd0); idle(1);
    chk("pre_reset_rd", 64'(bus.mmio_rd_data), 64'hA000_0020);
    issue(1'b1, 1'b0, 21'h061, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_rd_data", 64'(bus.mmio_rd_data), 64'd0);
    chk("midreset_strobes", 64'(cs_arr | rd_arr | wr_arr), 64'd0);
    rst = 1'b0;
    idle(2);
    chk("post_reset_rd_data", 64'(bus.mmio_rd_data), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
